regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised integer register file for the rv32i core. It has NRD combinational
//  read ports, one write port, optional write-to-read bypass, and a per-register
//  busy scoreboard. It sits between decode (reads operands, issues destinations)
//  and writeback. It stalls issue on WAW hazards and flags RAW hazards on each read.
// PARAMETERS
//  XLEN      32        data width of each register
//  NREGS     32        register count (power of 2, >=2); AW = $clog2(NREGS)
//  NRD       2         number of read ports (>=1)
//  SP_IDX    2         index of the register loaded with SP_RESET on reset
//  SP_RESET  32'h3FF   reset value of register SP_IDX; all others reset to 0
//  BYPASS    1         1: same-cycle writeback data is forwarded to the reads
// PORTS
//  clk          in   1         core clock; all state on rising edge
//  rst          in   1         synchronous reset, active-high
//  rd_addr_i    in   NRD*AW    read addresses; port k uses [k*AW +: AW]
//  rd_data_o    out  NRD*XLEN  read data; port k uses [k*XLEN +: XLEN]
//  rd_busy_o    out  NRD       1: read k targets a register with a pending writer
//  wb_we_i      in   1         writeback enable
//  wb_addr_i    in   AW        writeback destination
//  wb_data_i    in   XLEN      writeback data
//  iss_valid_i  in   1         decode requests to issue an instr writing iss_rd_i
//  iss_rd_i     in   AW        destination of the issuing instruction
//  iss_ready_o  out  1         1: the issue is accepted this cycle
//  busy_cnt_o   out  AW+1      number of registers currently busy
// BEHAVIOUR
//  Reset (rst=1 at posedge): regs[i]=0 for all i except regs[SP_IDX]=SP_RESET.
//   All busy bits clear. After reset: busy_cnt_o=0, rd_busy_o=0, iss_ready_o=1.
//   Reset overrides any wb or issue in the same cycle. Mid-operation reset drops
//   all pending writers.
//  x0: always reads 0 and is never busy. Writes to x0 are dropped. An issue to x0
//   is always accepted and sets nothing.
//  Read (combinational, 0 latency): rd_data_o[k]=regs[rd_addr_i[k]].
//   If BYPASS and wb_we_i and wb_addr_i==rd_addr_i[k]!=0: data=wb_data_i and
//   rd_busy_o[k]=0. Otherwise rd_busy_o[k]=busy[rd_addr_i[k]].
//  Write: if wb_we_i and wb_addr_i!=0, regs[wb_addr_i]<=wb_data_i at posedge.
//   The new value is visible to reads on the next cycle, or the same cycle via bypass.
//  Scoreboard, evaluated per cycle (not reset):
//   iss_ready_o = !busy[iss_rd_i] || (wb_we_i && wb_addr_i==iss_rd_i), or iss_rd_i==0.
//    It depends on iss_rd_i, not on iss_valid_i.
//   issue fires = iss_valid_i && iss_ready_o && iss_rd_i!=0 -> busy[iss_rd_i]<=1.
//   writeback clears: wb_we_i && wb_addr_i!=0 -> busy[wb_addr_i]<=0.
//   Same register issued and written back in one cycle: the set wins (new producer).
//   Writeback to a non-busy register is legal: a plain write, scoreboard unchanged.
//   Issue while not ready: no state change. Decode holds iss_valid_i/iss_rd_i.
//  busy_cnt_o: registered popcount of busy bits; updates with the bits (1-cycle).
//   Range 0..NREGS-1, no wrap possible.
//  No multi-cycle state machine. The scoreboard is a per-register 2-state FSM:
//   IDLE -issue-> BUSY -wb(no same-cycle issue)-> IDLE; BUSY -wb+issue-> BUSY.
// STRUCTURE
//  rv32i_pkg: XLEN, NREGS, REG_AW, SP_IDX, SP_RESET constants; reg_addr_t typedef.
//  Sub-module regfile_busy_tracker: busy vector, issue/clear arbitration,
//   iss_ready_o, busy_cnt_o; exposes the busy vector to the parent for rd_busy_o.
//  The parent holds the storage array, read muxes and bypass.
// TESTING
//  1 Reset: rst=1 2 cycles -> read x2=32'h3FF, x5=0, busy_cnt_o=0, iss_ready_o=1.
//  2 x0: wb x0<=32'hDEAD, issue x0 -> read x0=0, busy_cnt_o=0, iss_ready_o=1.
//  3 Bypass: wb x7<=32'h1234 while port0 reads x7 -> same cycle 32'h1234, busy=0;
//    with BYPASS=0 -> old value, then 32'h1234 next cycle.
//  4 RAW/WAW: issue x5 -> next cycle rd_busy_o=1 for x5, busy_cnt_o=1;
//    issue x5 again -> iss_ready_o=0; wb x5 -> busy clears, busy_cnt_o=0.
//  5 Simultaneous: x9 busy; issue x9 and wb x9 same cycle -> iss_ready_o=1,
//    x9 stays busy, busy_cnt_o unchanged, x9 holds wb data.
//  6 Reset mid-op: x3,x4,x6 busy, rst=1 one cycle -> all busy 0, x2=32'h3FF.

Source files
------------

// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared constants and types for the rv32i integer register file and its busy scoreboard.
package regfile_mp_scoreboard_pkg;

  localparam int unsigned       RF_XLEN     = 32;
  localparam int unsigned       RF_NREGS    = 32;
  localparam int unsigned       RF_NRD      = 2;
  localparam int unsigned       REG_AW      = $clog2(RF_NREGS);
  localparam int unsigned       RF_SP_IDX   = 2;
  localparam logic [RF_XLEN-1:0] RF_SP_RESET = 32'h3FF;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic {
    REG_IDLE = 1'b0,
    REG_BUSY = 1'b1
  } busy_state_t;

endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: operand reads, writeback, issue.
interface regfile_mp_scoreboard_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
);
  logic [NRD*AW-1:0]   rd_addr_i;
  logic [NRD*XLEN-1:0] rd_data_o;
  logic [NRD-1:0]      rd_busy_o;
  logic                wb_we_i;
  logic [AW-1:0]       wb_addr_i;
  logic [XLEN-1:0]     wb_data_i;
  logic                iss_valid_i;
  logic [AW-1:0]       iss_rd_i;
  logic                iss_ready_o;
  logic [AW:0]         busy_cnt_o;

  modport master (
    output rd_addr_i, wb_we_i, wb_addr_i, wb_data_i, iss_valid_i, iss_rd_i,
    input  rd_data_o, rd_busy_o, iss_ready_o, busy_cnt_o
  );

  modport slave (
    input  rd_addr_i, wb_we_i, wb_addr_i, wb_data_i, iss_valid_i, iss_rd_i,
    output rd_data_o, rd_busy_o, iss_ready_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-writer scoreboard: WAW issue gating, busy vector and registered busy count.
module regfile_busy_tracker
  import regfile_mp_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS = RF_NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  output logic             iss_ready,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]      busy_cnt
);

  busy_state_t st_q [NREGS];
  busy_state_t st_d [NREGS];
  logic [AW:0] cnt_d;
  logic        iss_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) st_q[i] <= REG_IDLE;
      busy_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) st_q[i] <= st_d[i];
      busy_cnt <= cnt_d;
    end
  end

  always_comb begin
    iss_ready = (iss_rd == '0) || (st_q[iss_rd] == REG_IDLE) || (wb_we && (wb_addr == iss_rd));
    iss_fire  = iss_valid && iss_ready && (iss_rd != '0);
    busy_vec  = '0;
    cnt_d     = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      st_d[i]     = st_q[i];
      busy_vec[i] = (st_q[i] == REG_BUSY);
      // x0 never leaves IDLE; the set is applied after the clear so a new producer wins.
      if (i != 0) begin
        if (wb_we && (wb_addr == AW'(i))) st_d[i] = REG_IDLE;
        if (iss_fire && (iss_rd == AW'(i))) st_d[i] = REG_BUSY;
      end
      cnt_d = cnt_d + (AW+1)'(st_d[i] == REG_BUSY);
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port integer register file with writeback bypass and WAW/RAW busy scoreboard.
module regfile_mp_scoreboard
  import regfile_mp_scoreboard_pkg::*;
#(
  parameter int unsigned     XLEN     = RF_XLEN,
  parameter int unsigned     NREGS    = RF_NREGS,
  parameter int unsigned     NRD      = RF_NRD,
  parameter int unsigned     SP_IDX   = RF_SP_IDX,
  parameter logic [XLEN-1:0] SP_RESET = RF_SP_RESET,
  parameter bit              BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  regfile_mp_scoreboard_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    busy_vec;
  logic                wb_fire;
  logic [AW-1:0]       ra;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;

  assign wb_fire = bus.wb_we_i && (bus.wb_addr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
    end else if (wb_fire) begin
      regs_q[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  // A forwarded read is by definition no longer waiting on its producer.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = bus.rd_addr_i[k*AW +: AW];
      if (ra != '0) begin
        if (BYPASS && wb_fire && (bus.wb_addr_i == ra)) begin
          rd_data[k*XLEN +: XLEN] = bus.wb_data_i;
        end else begin
          rd_data[k*XLEN +: XLEN] = regs_q[ra];
          rd_busy[k]              = busy_vec[ra];
        end
      end
    end
  end

  assign bus.rd_data_o = rd_data;
  assign bus.rd_busy_o = rd_busy;

  regfile_busy_tracker #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (bus.iss_valid_i),
    .iss_rd    (bus.iss_rd_i),
    .wb_we     (bus.wb_we_i),
    .wb_addr   (bus.wb_addr_i),
    .iss_ready (bus.iss_ready_o),
    .busy_vec  (busy_vec),
    .busy_cnt  (bus.busy_cnt_o)
  );

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: one bypassing and one non-bypassing register file driven in lockstep.
module tb_regfile_mp_scoreboard;
  import regfile_mp_scoreboard_pkg::*;

  localparam int unsigned XL = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = REG_AW;
  localparam int unsigned NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            t_we, t_iv;
  reg_addr_t       t_wa, t_ird;
  logic [XL-1:0]   t_wd;
  logic [NP*AW-1:0] t_ra;

  regfile_mp_scoreboard_if #(.XLEN(XL), .AW(AW), .NRD(NP)) bus_b ();
  regfile_mp_scoreboard_if #(.XLEN(XL), .AW(AW), .NRD(NP)) bus_n ();

  assign bus_b.rd_addr_i = t_ra;  assign bus_n.rd_addr_i = t_ra;
  assign bus_b.wb_we_i = t_we;    assign bus_n.wb_we_i = t_we;
  assign bus_b.wb_addr_i = t_wa;  assign bus_n.wb_addr_i = t_wa;
  assign bus_b.wb_data_i = t_wd;  assign bus_n.wb_data_i = t_wd;
  assign bus_b.iss_valid_i = t_iv; assign bus_n.iss_valid_i = t_iv;
  assign bus_b.iss_rd_i = t_ird;  assign bus_n.iss_rd_i = t_ird;

  regfile_mp_scoreboard #(
    .XLEN(XL), .NREGS(NR), .NRD(NP), .SP_IDX(2), .SP_RESET(32'h3FF), .BYPASS(1'b1)
  ) u_byp (.clk(clk), .rst(rst), .bus(bus_b));

  regfile_mp_scoreboard #(
    .XLEN(XL), .NREGS(NR), .NRD(NP), .SP_IDX(2), .SP_RESET(32'h3FF), .BYPASS(1'b0)
  ) u_nobyp (.clk(clk), .rst(rst), .bus(bus_n));

  typedef struct packed {
    logic [63:0] data_b;
    logic [63:0] data_n;
    logic [1:0]  busy_b;
    logic [1:0]  busy_n;
    logic        ready;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: architectural register values and pending-writer flags.
  logic [31:0] m_regs [NR];
  bit          m_busy [NR];
  bit          m_valid = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit we, input int wa, input logic [31:0] wd,
                      input bit iv, input int ird, input int ra0, input int ra1);
    exp_t e;
    int   a;
    int   cnt;
    bit   rdy;
    @(posedge clk);
    #1;
    rst   = r;
    t_we  = we;
    t_wa  = AW'(wa);
    t_wd  = wd;
    t_iv  = iv;
    t_ird = AW'(ird);
    t_ra  = {AW'(ra1), AW'(ra0)};

    rdy = (ird == 0) || !m_busy[ird] || (we && wa == ird);
    if (m_valid) begin
      e = '0;
      e.ready = rdy;
      for (int k = 0; k < 2; k++) begin
        a = (k == 0) ? ra0 : ra1;
        if (a != 0) begin
          e.data_n[k*32 +: 32] = m_regs[a];
          e.busy_n[k]          = m_busy[a];
          if (we && wa == a) begin
            e.data_b[k*32 +: 32] = wd;
            e.busy_b[k]          = 1'b0;
          end else begin
            e.data_b[k*32 +: 32] = m_regs[a];
            e.busy_b[k]          = m_busy[a];
          end
        end
      end
      cnt = 0;
      for (int i = 0; i < NR; i++) cnt += m_busy[i] ? 1 : 0;
      e.cnt = 6'(cnt);
      exp_q.push_back(e);
    end

    if (r) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = 32'h0;
        m_busy[i] = 1'b0;
      end
      m_regs[2] = 32'h3FF;
      m_valid   = 1'b1;
    end else begin
      if (we && wa != 0) begin
        m_regs[wa] = wd;
        m_busy[wa] = 1'b0;
      end
      if (iv && rdy && ird != 0) m_busy[ird] = 1'b1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data byp",   bus_b.rd_data_o,   e.data_b);
        check("rd_busy byp",   bus_b.rd_busy_o,   e.busy_b);
        check("iss_ready byp", bus_b.iss_ready_o, e.ready);
        check("busy_cnt byp",  bus_b.busy_cnt_o,  e.cnt);
        check("rd_data nobyp",   bus_n.rd_data_o,   e.data_n);
        check("rd_busy nobyp",   bus_n.rd_busy_o,   e.busy_n);
        check("iss_ready nobyp", bus_n.iss_ready_o, e.ready);
        check("busy_cnt nobyp",  bus_n.busy_cnt_o,  e.cnt);
      end
    end
  end

  initial begin : driver
    int wa, ird;
    rst = 1'b1; t_we = 1'b0; t_wa = '0; t_wd = '0; t_iv = 1'b0; t_ird = '0; t_ra = '0;

    step(1, 0, 0, 0, 0, 0, 2, 5);
    step(1, 0, 0, 0, 0, 0, 2, 5);
    step(0, 0, 0, 0, 0, 0, 2, 5);

    step(0, 1, 0, 32'hDEAD, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 2);

    step(0, 1, 7, 32'h1234, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 7, 0);

    step(0, 0, 0, 0, 1, 5, 5, 0);
    step(0, 0, 0, 0, 1, 5, 5, 0);
    step(0, 1, 5, 32'h5555, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);

    step(0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 1, 9, 32'h9999, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 9, 0);
    step(0, 1, 9, 32'hAAAA, 0, 0, 9, 0);

    step(0, 0, 0, 0, 1, 3, 3, 0);
    step(0, 0, 0, 0, 1, 4, 4, 0);
    step(0, 0, 0, 0, 1, 6, 6, 3);
    step(1, 1, 4, 32'hBEEF, 1, 7, 4, 6);
    step(0, 0, 0, 0, 0, 0, 3, 2);

    for (int n = 0; n < 800; n++) begin
      wa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      ird = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
           $urandom_range(0, 2) != 0, ird,
           int'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, 31)));
    end

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
